// File: rtl/gf2_31_pkg.sv
// Shared definitions for the GF(2^31) PRNG: field degree, step size,
// reduction polynomial terms and the sequencing FSM state type.
// Not timed: declarations only. No handshake of its own.
package gf2_31_pkg;

    // Field degree and the number of x-multiplications per PRNG step.
    localparam int GF_DEG    = 31;
    localparam int STEP_BITS = 4;

    // Terms of h(x) = x^31 + x^13 + x^8 + x^3 + 1 that lie below x^31.
    localparam logic [GF_DEG-1:0] H_LOW = 31'h2109;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } prng_state_e;

    // Zero is absorbing under multiplication, so it is swapped for 1.
    function automatic logic [GF_DEG-1:0] seed_sanitize(input logic [GF_DEG-1:0] seed);
        return (seed == '0) ? GF_DEG'(1) : seed;
    endfunction

endpackage

// File: rtl/gf2_poly_mod_35.sv
// Reduces a 35-bit polynomial over GF(2) modulo h(x) to a 31-bit remainder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   poly_i  35-bit input polynomial, bit i is the coefficient of x^i
//   rem_o   31-bit remainder modulo h(x)
module gf2_poly_mod_35
    import gf2_31_pkg::*;
(
    input  logic [GF_DEG+STEP_BITS-1:0] poly_i,
    output logic [GF_DEG-1:0]           rem_o
);

    localparam int IN_W = GF_DEG + STEP_BITS;

    // Full h(x) at input width, with the x^31 term included so that
    // cancelling a high bit clears it in the accumulator.
    localparam logic [IN_W-1:0] H_FULL = {{(STEP_BITS-1){1'b0}}, 1'b1, H_LOW};

    logic [IN_W-1:0] acc;

    // Long division from the top bit down. Shifted copies of h(x) only
    // reach x^(13+3), so no high bit can be re-created by a lower fold.
    always_comb begin
        acc = poly_i;
        for (int k = IN_W - 1; k >= GF_DEG; k--) begin
            if (acc[k]) begin
                acc = acc ^ (H_FULL << (k - GF_DEG));
            end
        end
        rem_o = acc[GF_DEG-1:0];
    end

endmodule

// File: rtl/gf2_31_prng_ctrl.sv
// GF(2^31) PRNG sequencer: steps state by x^4 mod h(x), seed load, skip-ahead.
// Latency: seed/handshake visible next cycle; skip of N returns valid after N+1 busy cycles.
// Backpressure: out_valid/out_ready stream, word held while out_ready is low; skip_ready only in RUN.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   seed_valid/data     seed load, accepted in any state, highest priority
//   skip_valid/count    skip-ahead request, discards skip_count steps
//   skip_ready          high in RUN while no seed is being loaded
//   out_valid/ready/data  PRNG word stream, out_data is the current state
//   busy                high while skipping
//   stat_count          delivered word count, only when GF2_PRNG_STATS_EN is defined
module gf2_31_prng_ctrl
    import gf2_31_pkg::*;
#(
    parameter int SKIP_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_valid,
    input  logic [GF_DEG-1:0]   seed_data,
    input  logic                skip_valid,
    input  logic [SKIP_W-1:0]   skip_count,
    output logic                skip_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [GF_DEG-1:0]   out_data,
    output logic                busy
`ifdef GF2_PRNG_STATS_EN
    ,
    output logic [31:0]         stat_count
`endif
);

    prng_state_e         fsm_q;
    logic [GF_DEG-1:0]   data_q;
    logic [GF_DEG-1:0]   step_d;
    logic [SKIP_W-1:0]   cnt_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                handshake;

    // The single reducer: state * x^4 folded back into the field.
    gf2_poly_mod_35 u_reduce (
        .poly_i ({data_q, {STEP_BITS{1'b0}}}),
        .rem_o  (step_d)
    );

    assign handshake  = out_valid_q && out_ready;
    assign skip_ready = (fsm_q == RUN) && !seed_valid;

    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (seed_valid) begin
            // Seed wins over everything: aborts a skip and replaces the
            // step that a same-cycle handshake would otherwise cause.
            fsm_q       <= RUN;
            data_q      <= seed_sanitize(seed_data);
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                RUN: begin
                    if (handshake) begin
                        data_q <= step_d;
                    end
                    if (skip_valid && skip_ready) begin
                        fsm_q       <= SKIP;
                        cnt_q       <= skip_count;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SKIP: begin
                    if (cnt_q != '0) begin
                        data_q <= step_d;
                        cnt_q  <= cnt_q - SKIP_W'(1);
                    end else begin
                        // Counter drained: the zero-count cycle is the
                        // trailing bubble before output resumes.
                        fsm_q       <= RUN;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GF2_PRNG_STATS_EN
    logic [31:0] stat_q;

    // Counts every accepted word, including one handed over while a seed
    // overrides the step. Seeds never clear it; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (handshake) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_gf2_31_prng_ctrl.sv
module tb_gf2_31_prng_ctrl;

    localparam int SKIP_W = 16;

    logic              clk;
    logic              rst;
    logic              seed_valid;
    logic [30:0]       seed_data;
    logic              skip_valid;
    logic [SKIP_W-1:0] skip_count;
    logic              skip_ready;
    logic              out_valid;
    logic              out_ready;
    logic [30:0]       out_data;
    logic              busy;
`ifdef GF2_PRNG_STATS_EN
    logic [31:0]       stat_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model in spec terms: a field element, whether a seed has
    // been seen, and the number of skip steps still to discard (-1 = none).
    logic [30:0] m_state;
    bit          m_have_seed;
    int          m_skip_rem;
    logic [31:0] m_stat;

    gf2_31_prng_ctrl #(.SKIP_W(SKIP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .skip_valid (skip_valid),
        .skip_count (skip_count),
        .skip_ready (skip_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
`ifdef GF2_PRNG_STATS_EN
        ,
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiply by x four times, reducing by h(x) whenever x^31 appears.
    function automatic logic [30:0] mul_x4(input logic [30:0] a);
        logic [31:0] v;
        v = {1'b0, a};
        for (int i = 0; i < 4; i++) begin
            v = v << 1;
            if (v[31]) v = v ^ 32'h8000_2109;
        end
        return v[30:0];
    endfunction

    function automatic bit m_valid();
        return m_have_seed && (m_skip_rem < 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state     = '0;
        m_have_seed = 1'b0;
        m_skip_rem  = -1;
        m_stat      = '0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the
    // model with the same inputs the DUT will sample at the next posedge.
    task automatic cycle(input bit sv, input logic [30:0] sd, input bit kv,
                         input logic [SKIP_W-1:0] kc, input bit ordy);
        bit vld, hs;
        @(negedge clk);
        seed_valid = sv;
        seed_data  = sd;
        skip_valid = kv;
        skip_count = kc;
        out_ready  = ordy;
        #1;
        vld = m_valid();
        chk("out_valid",  32'(out_valid),  32'(vld));
        chk("busy",       32'(busy),       32'(m_skip_rem >= 0));
        chk("out_data",   32'(out_data),   32'(m_state));
        chk("skip_ready", 32'(skip_ready), 32'(vld && !sv));
`ifdef GF2_PRNG_STATS_EN
        chk("stat_count", stat_count, m_stat);
`endif
        hs = vld && ordy;
        if (hs) m_stat = m_stat + 32'd1;
        if (sv) begin
            m_state     = (sd == '0) ? 31'h1 : sd;
            m_have_seed = 1'b1;
            m_skip_rem  = -1;
        end else if (vld) begin
            if (hs) m_state = mul_x4(m_state);
            if (kv) m_skip_rem = int'(kc);
        end else if (m_skip_rem > 0) begin
            m_state    = mul_x4(m_state);
            m_skip_rem = m_skip_rem - 1;
        end else if (m_skip_rem == 0) begin
            m_skip_rem = -1;
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, '0, 1'b0, '0, ordy);
    endtask

    // Spot check against a fixed value shortly after the active edge.
    task automatic expect_data(input string tag, input logic [30:0] exp);
        #2;
        chk(tag, 32'(out_data), 32'(exp));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;

        rst        = 1'b1;
        seed_valid = 1'b0;
        seed_data  = '0;
        skip_valid = 1'b0;
        skip_count = '0;
        out_ready  = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores skips and produces nothing.
        cycle(1'b0, '0, 1'b1, 16'd3, 1'b1);
        idle(1'b1);

        // Seed 1 with ready high: powers of x^4, then the first wrap.
        cycle(1'b1, 31'h1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            r = (i < 8) ? (32'h1 << (4 * i)) : 32'h0000_4212;
            expect_data("seq_word", r[30:0]);
            idle(1'b1);
        end

        // x^30 steps into x^34 reduced; zero seed becomes 1.
        cycle(1'b1, 31'h4000_0000, 1'b0, '0, 1'b0);
        expect_data("seed_x30", 31'h4000_0000);
        idle(1'b1);
        expect_data("x30_step", 31'h0001_0848);
        cycle(1'b1, 31'h0, 1'b0, '0, 1'b0);
        expect_data("seed_zero", 31'h1);

        // Skip 8 with no handshake: nine busy cycles, then step^8(1).
        cycle(1'b1, 31'h1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'd8, 1'b0);
        for (int i = 0; i < 9; i++) begin
            #2 chk("skip8_busy", 32'(busy), 32'd1);
            idle(1'b0);
        end
        expect_data("skip8_word", 31'h0000_4212);
        chk("skip8_valid", 32'(out_valid), 32'd1);

        // Skip 0: one bubble, unchanged word.
        cycle(1'b0, '0, 1'b1, 16'd0, 1'b0);
        #2 chk("skip0_busy", 32'(busy), 32'd1);
        idle(1'b0);
        expect_data("skip0_word", 31'h0000_4212);

        // Skip 8 together with a handshake: nine steps in total.
        cycle(1'b1, 31'h1, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'd8, 1'b1);
        repeat (9) idle(1'b1);
        expect_data("skip8_hs_word", 31'h0004_2120);

        // Seed during a skip aborts it.
        cycle(1'b0, '0, 1'b1, 16'd20, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b1, 31'h0123_4567, 1'b0, '0, 1'b0);
        expect_data("abort_word", 31'h0123_4567);
        chk("abort_busy", 32'(busy), 32'd0);

        // Backpressure then a seed overriding a handshake.
        repeat (3) idle(1'b0);
        cycle(1'b1, 31'h7654_3210, 1'b0, '0, 1'b1);
        expect_data("override_word", 31'h7654_3210);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r  = $urandom;
            r2 = $urandom;
            cycle(($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) == 0) ? 31'h0 : r[30:0],
                  ($urandom_range(0, 7) == 0),
                  SKIP_W'($urandom_range(0, 10)),
                  r2[0] | r2[1]);
        end

        // Asynchronous reset in the middle of a skip.
        cycle(1'b1, 31'h5, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, 16'd30, 1'b0);
        idle(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_skip_rdy",  32'(skip_ready), 32'd0);
`ifdef GF2_PRNG_STATS_EN
        chk("arst_stat", stat_count, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle(1'b1);

        // Delivered-word accounting across a reload.
        cycle(1'b1, 31'h9, 1'b0, '0, 1'b0);
        repeat (5) idle(1'b1);
        cycle(1'b1, 31'h3, 1'b0, '0, 1'b0);
        repeat (3) idle(1'b1);
        repeat (4) idle(1'b0);
`ifdef GF2_PRNG_STATS_EN
        #2 chk("stat_eight", stat_count, 32'd8);
`endif
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf2_31_prng_ctrl.md
# gf2_31_prng_ctrl

Sequencing controller for the GF(2^31) PRNG. It holds a 31-bit field element, steps it by multiplication with x^4 modulo h(x) = x^31 + x^13 + x^8 + x^3 + 1, and delivers one word per step over a valid/ready stream. It also supports seed loading and multi-cycle skip-ahead, and is the only owner of the 35-bit polynomial reducer in the PRNG top.

## Interface
- SKIP_W, 16, width of the skip-ahead step count
- clk  in  1  clock; all state on the rising edge
- rst  in  1  reset, asynchronous, active-high
- seed_valid  in  1  load request; accepted unconditionally in the same cycle
- seed_data  in  31  seed polynomial; bit i is the coefficient of x^i
- skip_valid  in  1  skip-ahead request
- skip_count  in  SKIP_W  number of steps to discard
- skip_ready  out  1  high only in RUN while seed_valid is low (combinational)
- out_valid  out  1  out_data holds a valid PRNG word
- out_ready  in  1  consumer accepts the word
- out_data  out  31  current state
- busy  out  1  high in SKIP
- stat_count  out  32  words delivered; present only with GF2_PRNG_STATS_EN

## Operation
- One step: next = reduce({state, 4'b0000}), using the 35-bit reducer, which is combinational with one step per cycle.
- FSM states:
  - IDLE: reset state, no seed yet, out_valid = 0.
  - RUN: out_valid = 1.
  - SKIP: out_valid = 0, busy = 1.
- Seed load (any state): state <= seed_data; go to RUN.
  - seed_data == 0 is replaced by 31'h1, because zero is absorbing.
  - Seed has priority over every other event. It aborts an active SKIP and overrides a same-cycle output handshake. The word handed over in that cycle counts as delivered, and the state becomes the seed.
- RUN with out_valid && out_ready: state <= next.
- RUN with skip_valid && skip_ready: go to SKIP and load the counter with skip_count.
  - If an output handshake happens in the same cycle, the state also steps once in that cycle.
- SKIP: each cycle, if counter != 0, state <= next and counter decrements. When counter == 0, return to RUN.
  - skip_count = 0 therefore gives a one-cycle bubble and no state change.
- skip_valid in IDLE or SKIP is ignored, and skip_ready stays low.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset values: state = 0, FSM = IDLE, out_valid = 0, busy = 0, skip_ready = 0, counter = 0, stat_count = 0.
- Seed accepted in cycle T: out_valid = 1 and out_data = seed in cycle T+1.
- Handshake in cycle T: the next word appears in cycle T+1; sustained throughput is one word per clock.
- Skip of N accepted in cycle T: out_valid = 0 from T+1 through T+N+1, and out_valid = 1 again in T+N+2.
- Reset asserted mid-skip or mid-stream: all outputs return to their reset values immediately (asynchronously). The first cycle after reset deassertion is IDLE.

## Configuration
- GF2_PRNG_STATS_EN defined:
  - Adds the 32-bit stat_count port.
  - stat_count increments on each out_valid && out_ready, including in a seed-override cycle, and wraps from 0xFFFFFFFF to 0.
  - Seed loads do not clear it; only rst does.
- GF2_PRNG_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package gf2_31_pkg:
  - GF_DEG = 31, STEP_BITS = 4.
  - H_LOW = 31'h2109 (the terms of h(x) below x^31).
  - The FSM state enum (IDLE, RUN, SKIP).
- Instantiates the team's 35-bit reducer gf2_poly_mod_35 as its single sub-module. No other sub-module.

## Test plan
- Reset: assert rst mid-operation -> out_valid = 0, busy = 0, out_data = 0 immediately; no output until a seed is loaded.
- Seed 31'h1 with out_ready held high -> out_data sequence 0x1, 0x10, 0x100, …, 0x10000000, then 0x00004212 on the 9th word.
- Seed 0x40000000, one handshake -> second word = 0x00010848; seed 0 -> first word = 0x00000001.
- Seed 1, then skip_count = 8 with no handshake -> busy for 9 cycles, then out_data = 0x00004212. skip_count = 0 -> one bubble, out_data unchanged.
- Seed 1, skip 8 accepted in the same cycle as a handshake -> resulting word = step^9(1) = 0x00042120. A seed during SKIP -> skip aborted, next word = the new seed.
- With GF2_PRNG_STATS_EN: 5 handshakes, a seed reload, then 3 more -> stat_count = 8. Backpressure (out_ready low) -> out_data stable and count unchanged.
